// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: execute-stage store request, data SRAM write
// port and the load-probe lines. The master drives stores, SRAM accepts
// and load probes. The slave (the store buffer) answers them.
interface store_buffer_if;
    logic        es_st_valid;
    logic [4:0]  es_st_op;
    logic [31:0] es_st_addr;
    logic [31:0] es_st_rt;
    logic        stb_allowin;
    logic        data_sram_req;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        stb_ld_hazard;
    logic        stb_empty;

    modport master (
        output es_st_valid, es_st_op, es_st_addr, es_st_rt,
        input  stb_allowin,
        input  data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok,
        output ld_valid, ld_addr,
        input  stb_ld_hazard, stb_empty
    );

    modport slave (
        input  es_st_valid, es_st_op, es_st_addr, es_st_rt,
        output stb_allowin,
        output data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok,
        input  ld_valid, ld_addr,
        output stb_ld_hazard, stb_empty
    );
endinterface

// File: rtl/store_buffer.sv
// Two-entry store buffer between the execute stage and the data SRAM.
// Stores are lane-aligned on entry (sb/sh/sw/swl/swr) and drained in
// acceptance order, one per accepted SRAM request, with no byte merging.
// Optional feature: define STB_LD_HAZARD_EN to enable word-address
// comparison of a probing load against the occupied entries. Without it
// stb_ld_hazard is tied low and no comparators exist.
module store_buffer (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } entry_t;

    entry_t     ent_q [2];
    entry_t     ent_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;
    entry_t     new_ent;

    // Byte-lane alignment of a store; op is one-hot {swr,swl,sw,sh,sb}.
    function automatic entry_t align_store(input logic [4:0]  op,
                                           input logic [31:0] addr,
                                           input logic [31:0] rt);
        entry_t     e;
        logic [1:0] off;
        off     = addr[1:0];
        e.addr  = addr[31:2];
        e.wstrb = 4'b0000;
        e.wdata = rt;
        case (op)
            5'b00001: begin
                e.wstrb = 4'b0001 << off;
                e.wdata = {4{rt[7:0]}};
            end
            5'b00010: begin
                e.wstrb = off[1] ? 4'b1100 : 4'b0011;
                e.wdata = {2{rt[15:0]}};
            end
            5'b00100: begin
                e.wstrb = 4'b1111;
                e.wdata = rt;
            end
            5'b01000: begin
                case (off)
                    2'd0:    begin e.wstrb = 4'b0001; e.wdata = {24'b0, rt[31:24]}; end
                    2'd1:    begin e.wstrb = 4'b0011; e.wdata = {16'b0, rt[31:16]}; end
                    2'd2:    begin e.wstrb = 4'b0111; e.wdata = {8'b0, rt[31:8]};   end
                    default: begin e.wstrb = 4'b1111; e.wdata = rt;                 end
                endcase
            end
            5'b10000: begin
                case (off)
                    2'd0:    begin e.wstrb = 4'b1111; e.wdata = rt;                 end
                    2'd1:    begin e.wstrb = 4'b1110; e.wdata = {rt[23:0], 8'b0};  end
                    2'd2:    begin e.wstrb = 4'b1100; e.wdata = {rt[15:0], 16'b0}; end
                    default: begin e.wstrb = 4'b1000; e.wdata = {rt[7:0], 24'b0};  end
                endcase
            end
            default: begin
                // Malformed (multi-hot) op: the slot is consumed but writes no bytes.
                e.wstrb = 4'b0000;
                e.wdata = rt;
            end
        endcase
        return e;
    endfunction

    // Next-state: push at the tail, pop at the head, count tracks occupancy.
    always_comb begin
        new_ent  = align_store(sb.es_st_op, sb.es_st_addr, sb.es_st_rt);
        push     = sb.es_st_valid && (count_q != 2'd2) && (sb.es_st_op != 5'b0);
        pop      = (count_q != 2'd0) && sb.data_sram_addr_ok;
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ent_d[wr_ptr_q] = new_ent;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state: reset discards every pending entry and ignores the store port.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry payload: only meaningful while occupied, so it is never reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign sb.stb_allowin     = (count_q != 2'd2);
    assign sb.stb_empty       = (count_q == 2'd0);
    assign sb.data_sram_req   = (count_q != 2'd0);
    assign sb.data_sram_addr  = {ent_q[rd_ptr_q].addr, 2'b00};
    assign sb.data_sram_wstrb = ent_q[rd_ptr_q].wstrb;
    assign sb.data_sram_wdata = ent_q[rd_ptr_q].wdata;

`ifdef STB_LD_HAZARD_EN
    logic [1:0] occ;
    logic       unused_ld;

    // Occupied slots: both when full, only the head slot when one is pending.
    always_comb begin
        occ[0] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b0));
        occ[1] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b1));
    end

    assign sb.stb_ld_hazard = sb.ld_valid &&
                              ((occ[0] && (ent_q[0].addr == sb.ld_addr[31:2])) ||
                               (occ[1] && (ent_q[1].addr == sb.ld_addr[31:2])));
    assign unused_ld = &{1'b0, sb.ld_addr[1:0]};
`else
    logic unused_ld;
    assign sb.stb_ld_hazard = 1'b0;
    assign unused_ld = &{1'b0, sb.ld_valid, sb.ld_addr};
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus pushes expected SRAM writes
// into a queue, a negedge monitor compares the DUT against that queue.
module tb_store_buffer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

`ifdef STB_LD_HAZARD_EN
    localparam logic HAZ_EN = 1'b1;
`else
    localparam logic HAZ_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];

    store_buffer_if sbif ();

    store_buffer dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference alignment written from the lane rules with plain arithmetic.
    function automatic void ref_store(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] rt,
                                      output logic [3:0] st, output logic [31:0] wd);
        int off;
        off = int'(a[1:0]);
        st  = 4'h0;
        wd  = 32'h0;
        if (op == 5'b00001) begin
            st = 4'(1 << off);
            wd = rt[7:0] * 32'h01010101;
        end else if (op == 5'b00010) begin
            st = 4'(3 << (off & 2));
            wd = rt[15:0] * 32'h00010001;
        end else if (op == 5'b00100) begin
            st = 4'hF;
            wd = rt;
        end else if (op == 5'b01000) begin
            st = 4'((1 << (off + 1)) - 1);
            wd = rt >> (8 * (3 - off));
        end else if (op == 5'b10000) begin
            st = 4'((15 << off) & 15);
            wd = rt << (8 * off);
        end
    endfunction

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] rt, input logic ok);
        exp_t e;
        sbif.es_st_valid       = v;
        sbif.es_st_op          = op;
        sbif.es_st_addr        = a;
        sbif.es_st_rt          = rt;
        sbif.data_sram_addr_ok = ok;
        if (v && op != 5'b0 && !reset && q.size() < 2) begin
            e.cyc  = cyc;
            e.addr = {a[31:2], 2'b00};
            ref_store(op, a, rt, e.wstrb, e.wdata);
            q.push_back(e);
        end
    endtask

    task automatic set_ld(input logic v, input logic [31:0] a);
        sbif.ld_valid = v;
        sbif.ld_addr  = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
        while (q.size() != 0 && k < 10) begin
            step();
            k++;
        end
        step();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
    endtask

    // Monitor: compare registered-state outputs against the model occupancy.
    always @(negedge clk) begin
        int   n;
        logic eh;
        n  = 0;
        eh = 1'b0;
        foreach (q[i]) begin
            if (q[i].cyc < cyc) begin
                n++;
                if (q[i].addr[31:2] == sbif.ld_addr[31:2]) eh = 1'b1;
            end
        end
        eh = eh && sbif.ld_valid && HAZ_EN;
        chk("allowin", 32'(sbif.stb_allowin), 32'(n != 2));
        chk("req", 32'(sbif.data_sram_req), 32'(n != 0));
        chk("empty", 32'(sbif.stb_empty), 32'(n == 0));
        chk("hazard", 32'(sbif.stb_ld_hazard), 32'(eh));
        if (n != 0) begin
            chk("head_addr", sbif.data_sram_addr, q[0].addr);
            chk("head_wstrb", 32'(sbif.data_sram_wstrb), 32'(q[0].wstrb));
            chk("head_wdata", sbif.data_sram_wdata, q[0].wdata);
        end
        if (reset) q.delete();
        else if (n != 0 && sbif.data_sram_addr_ok) void'(q.pop_front());
    end

    initial begin
        reset = 1'b1;
        set_ld(1'b0, 32'h0);
        drive(1'b1, 5'b00100, 32'h0, 32'h0, 1'b0);
        step();
        step();
        chk("rst_req", 32'(sbif.data_sram_req), 32'd0);
        chk("rst_empty", 32'(sbif.stb_empty), 32'd1);
        chk("rst_allowin", 32'(sbif.stb_allowin), 32'd1);
        reset = 1'b0;
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b0);
        step();

        // sb lane replication
        drive(1'b1, 5'b00001, 32'h1003, 32'h000000AB, 1'b0);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b0);
        chk("sb_req", 32'(sbif.data_sram_req), 32'd1);
        chk("sb_addr", sbif.data_sram_addr, 32'h1000);
        chk("sb_wstrb", 32'(sbif.data_sram_wstrb), 32'h8);
        chk("sb_wdata", sbif.data_sram_wdata, 32'hABABABAB);
        drain();

        // swl / swr at offset 1
        drive(1'b1, 5'b01000, 32'h2001, 32'h11223344, 1'b0);
        step();
        drive(1'b1, 5'b10000, 32'h2001, 32'h11223344, 1'b0);
        chk("swl_wstrb", 32'(sbif.data_sram_wstrb), 32'h3);
        chk("swl_wdata", sbif.data_sram_wdata, 32'h00001122);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b0);
        chk("swr_wstrb", 32'(sbif.data_sram_wstrb), 32'hE);
        chk("swr_wdata", sbif.data_sram_wdata, 32'h22334400);
        drain();

        // Fill, hold a third store, then drain in order
        drive(1'b1, 5'b00100, 32'h4000, 32'hA0A0A0A0, 1'b0);
        step();
        drive(1'b1, 5'b00100, 32'h4004, 32'hB1B1B1B1, 1'b0);
        step();
        chk("full_allowin", 32'(sbif.stb_allowin), 32'd0);
        drive(1'b1, 5'b00100, 32'h4008, 32'hC2C2C2C2, 1'b0);
        step();
        chk("held_allowin", 32'(sbif.stb_allowin), 32'd0);
        chk("held_head", sbif.data_sram_addr, 32'h4000);
        drive(1'b1, 5'b00100, 32'h4008, 32'hC2C2C2C2, 1'b1);
        step();
        chk("pop1_allowin", 32'(sbif.stb_allowin), 32'd1);
        chk("pop1_head", sbif.data_sram_addr, 32'h4004);
        drive(1'b1, 5'b00100, 32'h4008, 32'hC2C2C2C2, 1'b1);
        step();
        chk("pushpop_allowin", 32'(sbif.stb_allowin), 32'd1);
        chk("pushpop_head", sbif.data_sram_addr, 32'h4008);
        drain();

        // Reset mid-drain with addr_ok high
        drive(1'b1, 5'b00100, 32'h5000, 32'h1, 1'b0);
        step();
        drive(1'b1, 5'b00010, 32'h5006, 32'h2, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 5'b00001, 32'h5008, 32'h3, 1'b1);
        step();
        chk("rstmid_req", 32'(sbif.data_sram_req), 32'd0);
        chk("rstmid_empty", 32'(sbif.stb_empty), 32'd1);
        reset = 1'b0;
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("rstmid_req2", 32'(sbif.data_sram_req), 32'd0);

        // Load hazard probe
        drive(1'b1, 5'b00010, 32'h3002, 32'h5555, 1'b0);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0, 1'b0);
        set_ld(1'b1, 32'h3000);
        #1;
        chk("haz_match", 32'(sbif.stb_ld_hazard), 32'(HAZ_EN));
        set_ld(1'b1, 32'h3004);
        #1;
        chk("haz_miss", 32'(sbif.stb_ld_hazard), 32'd0);
        set_ld(1'b0, 32'h0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int          r;
            logic [4:0]  op;
            r     = int'($urandom_range(0, 5));
            op    = (r == 5) ? 5'b0 : 5'(1 << r);
            reset = ($urandom_range(0, 99) == 0);
            drive(logic'($urandom_range(0, 1)), op,
                  32'h3000 + 32'($urandom_range(0, 15)), $urandom,
                  logic'($urandom_range(0, 2) != 0));
            set_ld(logic'($urandom_range(0, 1)), 32'h3000 + 32'($urandom_range(0, 15)));
            step();
        end
        reset = 1'b0;
        set_ld(1'b0, 32'h0);
        drain();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
